fifo_access_scheduler: RTL and testbench

//  Sole owner of the 8x8 linear FIFO's wn/rn/DATAIN pins. Shares the write side among
//  N_WR producers (round-robin with burst lock) and interleaves a single consumer's reads.

---
 rtl/fifo_sched_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/fifo_access_scheduler.sv | 132 +++++++++++++
 tb/tb_fifo_access_scheduler.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sched_pkg.sv
// Shared definitions for the FIFO access scheduler.
//   DATA_W     : FIFO word width
//   OCC_W      : width of the occupancy counter (covers 0..15)
//   BURST_W    : width of the write burst counter (covers 1..15)
//   op_t       : last granted operation, used for read/write alternation
//   ptr_width  : width of a round-robin pointer over n requesters, never 0
package fifo_sched_pkg;

  localparam int DATA_W  = 8;
  localparam int OCC_W   = 4;
  localparam int BURST_W = 4;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } op_t;

  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker with an optional lock on one requester.
//   req      : request vector
//   ptr      : index of the most recently granted requester; the search starts after it
//   lock_en  : the locked requester keeps priority if it is still requesting
//   lock_idx : index of the locked requester
//   gnt      : one-hot grant (all zero when req is zero)
// All state lives in the caller.
module rr_arbiter
  import fifo_sched_pkg::*;
#(
  parameter  int N     = 4,
  localparam int PTR_W = ptr_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             lock_en,
  input  logic [PTR_W-1:0] lock_idx,
  output logic [N-1:0]     gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    // A live lock overrides the rotation.
    for (int i = 0; i < N; i++) begin
      if (lock_en && req[i] && (i == int'(lock_idx))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    // Rotation: first requester after ptr, wrapping; ptr itself is checked last.
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (i == (int'(ptr) + k) % N)) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_access_scheduler.sv
// Sole driver of a linear FIFO's wn/rn/DATAIN pins. Shares the write side among
// N_WR producers (round-robin with burst lock) and interleaves one consumer's reads.
// A private occupancy count caps the FIFO at DEPTH-1 entries, so the pointer wrap
// never makes a full FIFO look empty, and alternation keeps reads from starving.
//
// Ports:
//   clock, reset        : posedge clock, synchronous active-high reset (shared with the FIFO)
//   wr_req / wr_data    : producer i has wr_data[8*i+:8] pending
//   wr_gnt              : one-hot, combinational
//   rd_req / rd_gnt     : consumer request and combinational accept
//   rd_valid / rd_data  : returned word, two cycles after rd_gnt; rd_data wired from fifo_dout
//   fifo_wn/rn/din      : registered FIFO controls, single-cycle pulses
//   fifo_dout           : FIFO DATAOUT
//   occupancy           : entries issued and not yet read, 0..DEPTH-1
//
// Handshake: a grant (wr_gnt[i] or rd_gnt) high in a cycle means that request was
// taken at the end of that cycle; the requester may present new data or drop the
// request in the next cycle. Grants are forced low while reset is high.
module fifo_access_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int N_WR      = 4,
  parameter int DEPTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_WR-1:0]        wr_req,
  input  logic [N_WR*DATA_W-1:0] wr_data,
  output logic [N_WR-1:0]        wr_gnt,
  input  logic                   rd_req,
  output logic                   rd_gnt,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   fifo_wn,
  output logic                   fifo_rn,
  output logic [DATA_W-1:0]      fifo_din,
  input  logic [DATA_W-1:0]      fifo_dout,
  output logic [OCC_W-1:0]       occupancy
);

  localparam int                 PTR_W     = ptr_width(N_WR);
  localparam logic [OCC_W-1:0]   OCC_MAX   = OCC_W'(DEPTH - 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  // rr_ptr doubles as the burst holder; burst_cnt == 0 means no holder.
  logic [PTR_W-1:0]   rr_ptr;
  logic [BURST_W-1:0] burst_cnt;
  op_t                last_op;

  logic               wr_ok;
  logic               rd_ok;
  logic               wr_win;
  logic               rd_win;
  logic               lock_en;
  logic               lock_hit;
  logic [N_WR-1:0]    arb_gnt;
  logic [PTR_W-1:0]   gnt_idx;
  logic [DATA_W-1:0]  gnt_word;

  assign wr_ok = (|wr_req) && (occupancy < OCC_MAX);
  assign rd_ok = rd_req && (occupancy != '0);

  // With both eligible, a read wins only right after a write.
  assign wr_win = !reset && wr_ok && (!rd_ok || (last_op == OP_READ));
  assign rd_win = !reset && rd_ok && !wr_win;

  assign lock_en  = (burst_cnt != '0) && (burst_cnt < BURST_MAX);
  assign lock_hit = lock_en && wr_req[rr_ptr];

  rr_arbiter #(
    .N (N_WR)
  ) u_arb (
    .req      (wr_req),
    .ptr      (rr_ptr),
    .lock_en  (lock_en),
    .lock_idx (rr_ptr),
    .gnt      (arb_gnt)
  );

  always_comb begin
    gnt_idx  = '0;
    gnt_word = '0;
    for (int i = 0; i < N_WR; i++) begin
      if (arb_gnt[i]) begin
        gnt_idx  = PTR_W'(i);
        gnt_word = wr_data[DATA_W*i +: DATA_W];
      end
    end
  end

  assign wr_gnt  = wr_win ? arb_gnt : '0;
  assign rd_gnt  = rd_win;
  assign rd_data = fifo_dout;

  always_ff @(posedge clock) begin
    if (reset) begin
      fifo_wn   <= 1'b0;
      fifo_rn   <= 1'b0;
      fifo_din  <= '0;
      rd_valid  <= 1'b0;
      occupancy <= '0;
      rr_ptr    <= PTR_W'(N_WR - 1);
      burst_cnt <= '0;
      last_op   <= OP_READ;
    end else begin
      fifo_wn  <= wr_win;
      fifo_rn  <= rd_win;
      // FIFO DATAOUT updates on the edge that samples rn, so valid trails rn by one cycle.
      rd_valid <= fifo_rn;
      if (wr_win) begin
        fifo_din  <= gnt_word;
        occupancy <= occupancy + OCC_W'(1);
        last_op   <= OP_WRITE;
        rr_ptr    <= gnt_idx;
        // A rotation pick (including the same port re-picked after its burst
        // expired) starts a fresh burst.
        burst_cnt <= lock_hit ? burst_cnt + BURST_W'(1) : BURST_W'(1);
      end else begin
        if (rd_win) begin
          occupancy <= occupancy - OCC_W'(1);
          last_op   <= OP_READ;
        end
        // A holder that stops requesting gives up its lock; reads alone keep it.
        if (!wr_req[rr_ptr]) begin
          burst_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_access_scheduler.sv
// Self-checking bench for fifo_access_scheduler: directed tables and sequences plus
// randomized traffic checked by a cycle-level reference model and a FIFO model.
module tb_fifo_access_scheduler;

  localparam int N_WR      = 4;
  localparam int DEPTH     = 8;
  localparam int MAX_BURST = 4;

  logic        clock;
  logic        reset;
  logic [3:0]  wr_req;
  logic [31:0] wr_data;
  logic [3:0]  wr_gnt;
  logic        rd_req;
  logic        rd_gnt;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        fifo_wn;
  logic        fifo_rn;
  logic [7:0]  fifo_din;
  logic [7:0]  fifo_dout;
  logic [3:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_access_scheduler #(
    .N_WR(N_WR), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .wr_gnt    (wr_gnt),
    .rd_req    (rd_req),
    .rd_gnt    (rd_gnt),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .fifo_wn   (fifo_wn),
    .fifo_rn   (fifo_rn),
    .fifo_din  (fifo_din),
    .fifo_dout (fifo_dout),
    .occupancy (occupancy)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- linear FIFO model (8x8, registered DATAOUT) ----------------
  logic [7:0] mem [8];
  logic [2:0] f_wp;
  logic [2:0] f_rp;

  always @(posedge clock) begin
    if (reset) begin
      f_wp      <= '0;
      f_rp      <= '0;
      fifo_dout <= '0;
    end else begin
      if (fifo_wn) begin
        mem[f_wp] <= fifo_din;
        f_wp      <= f_wp + 3'd1;
      end
      if (fifo_rn) begin
        fifo_dout <= mem[f_rp];
        f_rp      <= f_rp + 3'd1;
      end
    end
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the scheduler rules directly: count of words held, who owns the burst,
  // how long, which op went last, and the queue of words inside the FIFO.
  logic       model_ok = 1'b0;
  int         m_occ;
  logic [1:0] m_ptr;
  logic       m_has;
  int         m_burst;
  logic       m_last_wr;
  logic       m_wn, m_rn, m_rv;
  logic [7:0] m_din;
  logic [7:0] fifo_q[$];
  logic [7:0] ret_q[$];

  logic [3:0] e_wgnt;
  logic       e_rgnt;
  int         e_pick;
  logic       e_locked;
  logic       wok, rok;
  logic [1:0] cand;
  logic [7:0] got_word;

  always @(negedge clock) begin
    e_wgnt   = '0;
    e_rgnt   = 1'b0;
    e_pick   = -1;
    e_locked = 1'b0;
    if (model_ok) begin
      if (!reset) begin
        wok = (wr_req != 4'd0) && (m_occ < DEPTH - 1);
        rok = rd_req && (m_occ > 0);
        if (wok && (!rok || !m_last_wr)) begin
          if (m_has && wr_req[m_ptr] && (m_burst < MAX_BURST)) begin
            e_pick   = int'(m_ptr);
            e_locked = 1'b1;
          end else begin
            for (int k = 1; k <= N_WR; k++) begin
              cand = m_ptr + 2'(k);
              if (e_pick < 0 && wr_req[cand]) e_pick = int'(cand);
            end
          end
          e_wgnt[e_pick] = 1'b1;
        end else if (rok) begin
          e_rgnt = 1'b1;
        end
      end
      check("m_wr_gnt", 32'(wr_gnt), 32'(e_wgnt));
      check("m_rd_gnt", 32'(rd_gnt), 32'(e_rgnt));
      check("m_fifo_wn", 32'(fifo_wn), 32'(m_wn));
      check("m_fifo_rn", 32'(fifo_rn), 32'(m_rn));
      check("m_rd_valid", 32'(rd_valid), 32'(m_rv));
      check("m_occupancy", 32'(occupancy), 32'(m_occ));
      check("m_wn_rn_excl", 32'(fifo_wn & fifo_rn), 32'd0);
      if (m_wn) check("m_fifo_din", 32'(fifo_din), 32'(m_din));
      if (rd_valid) begin
        if (ret_q.size() == 0) begin
          check("m_rd_unexpected", 32'(rd_valid), 32'd0);
        end else begin
          got_word = ret_q.pop_front();
          check("m_rd_data", 32'(rd_data), 32'(got_word));
        end
      end
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      model_ok  <= 1'b1;
      m_occ     <= 0;
      m_ptr     <= 2'd3;
      m_has     <= 1'b0;
      m_burst   <= 0;
      m_last_wr <= 1'b0;
      m_wn      <= 1'b0;
      m_rn      <= 1'b0;
      m_rv      <= 1'b0;
      m_din     <= '0;
      fifo_q.delete();
      ret_q.delete();
    end else if (model_ok) begin
      m_rv <= m_rn;
      m_rn <= e_rgnt;
      m_wn <= (e_wgnt != 4'd0);
      if (e_wgnt != 4'd0) begin
        m_din     <= wr_data[8*e_pick +: 8];
        fifo_q.push_back(wr_data[8*e_pick +: 8]);
        m_occ     <= m_occ + 1;
        m_last_wr <= 1'b1;
        m_ptr     <= 2'(e_pick);
        m_has     <= 1'b1;
        m_burst   <= e_locked ? m_burst + 1 : 1;
      end else begin
        if (e_rgnt) begin
          ret_q.push_back(fifo_q.pop_front());
          m_occ     <= m_occ - 1;
          m_last_wr <= 1'b0;
        end
        if (m_has && !wr_req[m_ptr]) m_has <= 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after posedge; directed samples are taken 3 units later.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] wq, input logic rq, input logic [31:0] wd);
    wr_req  = wq;
    rd_req  = rq;
    wr_data = wd;
    #3;
  endtask

  task automatic reset_dut();
    reset  = 1'b1;
    wr_req = '0;
    rd_req = 1'b0;
    repeat (2) next_cycle();
    reset = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [3:0] wq;
    logic       rq;
    logic [3:0] exp_wgnt;
    logic       exp_rgnt;
    logic [3:0] exp_occ;
  } vec_t;

  vec_t       t3 [9];
  vec_t       t4 [6];
  logic [7:0] got[$];
  int         wn_pulses;

  initial begin
    reset   = 1'b1;
    wr_req  = '0;
    rd_req  = 1'b0;
    wr_data = '0;

    for (int i = 0; i < 9; i++)
      t3[i] = '{4'b1111, 1'b0, (i < 4) ? 4'b0001 : (i < 7) ? 4'b0010 : 4'b0000, 1'b0,
                (i < 7) ? 4'(i) : 4'd7};
    for (int i = 0; i < 6; i++)
      t4[i] = '{4'b0010, 1'b1, (i % 2 == 1) ? 4'b0010 : 4'b0000, (i % 2 == 0),
                (i % 2 == 0) ? 4'd3 : 4'd2};

    #1;
    reset_dut();

    // Reset state.
    drive(4'b0000, 1'b0, 32'h0);
    check("rst_wr_gnt", 32'(wr_gnt), 32'd0);
    check("rst_rd_gnt", 32'(rd_gnt), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_fifo_wn", 32'(fifo_wn), 32'd0);
    check("rst_fifo_rn", 32'(fifo_rn), 32'd0);
    check("rst_fifo_din", 32'(fifo_din), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    next_cycle();

    // Single producer fills up to the cap; the 8th word is held.
    wn_pulses = 0;
    for (int i = 0; i < 9; i++) begin
      drive(4'b0001, 1'b0, (i < 7) ? 32'(8'h11 + i) : 32'h18);
      check("t1_wr_gnt", 32'(wr_gnt), (i < 7) ? 32'd1 : 32'd0);
      if (fifo_wn) wn_pulses++;
      next_cycle();
    end
    check("t1_wn_pulses", 32'(wn_pulses), 32'd7);
    check("t1_occupancy", 32'(occupancy), 32'd7);

    // Drain all seven words in order.
    got.delete();
    for (int i = 0; i < 10; i++) begin
      drive(4'b0000, (i < 7), 32'h0);
      check("t2_rd_gnt", 32'(rd_gnt), 32'(i < 7));
      if (rd_valid) got.push_back(rd_data);
      next_cycle();
    end
    check("t2_count", 32'(got.size()), 32'd7);
    for (int k = 0; k < got.size(); k++) check("t2_rd_data", 32'(got[k]), 32'(8'h11 + k));
    drive(4'b0000, 1'b1, 32'h0);
    check("t2_occupancy", 32'(occupancy), 32'd0);
    check("t2_rd_gnt_empty", 32'(rd_gnt), 32'd0);
    next_cycle();

    // All producers requesting: burst lock then rotation, capped at 7.
    reset_dut();
    for (int i = 0; i < 9; i++) begin
      drive(t3[i].wq, t3[i].rq, 32'h44332211);
      check("t3_wr_gnt", 32'(wr_gnt), 32'(t3[i].exp_wgnt));
      check("t3_occupancy", 32'(occupancy), 32'(t3[i].exp_occ));
      next_cycle();
    end

    // Occupancy 3, then read and write both pending: strict alternation.
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0001, 1'b0, 32'(8'h60 + i));
      next_cycle();
    end
    for (int i = 0; i < 6; i++) begin
      drive(t4[i].wq, t4[i].rq, 32'h0000_7700 + 32'(i << 8));
      check("t4_wr_gnt", 32'(wr_gnt), 32'(t4[i].exp_wgnt));
      check("t4_rd_gnt", 32'(rd_gnt), 32'(t4[i].exp_rgnt));
      check("t4_occupancy", 32'(occupancy), 32'(t4[i].exp_occ));
      check("t4_wn_rn_excl", 32'(fifo_wn & fifo_rn), 32'd0);
      next_cycle();
    end

    // Write then immediate read of the same word from an empty FIFO.
    reset_dut();
    drive(4'b0001, 1'b0, 32'h0000_00A5);
    check("t5_wr_gnt", 32'(wr_gnt), 32'd1);
    next_cycle();
    drive(4'b0000, 1'b1, 32'h0);
    check("t5_rd_gnt", 32'(rd_gnt), 32'd1);
    check("t5_fifo_wn", 32'(fifo_wn), 32'd1);
    next_cycle();
    drive(4'b0000, 1'b0, 32'h0);
    check("t5_fifo_rn", 32'(fifo_rn), 32'd1);
    next_cycle();
    drive(4'b0000, 1'b0, 32'h0);
    check("t5_rd_valid", 32'(rd_valid), 32'd1);
    check("t5_rd_data", 32'(rd_data), 32'hA5);
    next_cycle();

    // Reset mid-operation discards in-flight work and restores port-0 priority.
    reset_dut();
    drive(4'b0100, 1'b0, 32'h003C_0000);
    check("t6_wr_gnt_p2", 32'(wr_gnt), 32'b0100);
    next_cycle();
    drive(4'b0000, 1'b1, 32'h0);
    check("t6_rd_gnt", 32'(rd_gnt), 32'd1);
    check("t6_fifo_wn", 32'(fifo_wn), 32'd1);
    next_cycle();
    reset = 1'b1;
    drive(4'b0100, 1'b0, 32'h0);
    check("t6_rn_pending", 32'(fifo_rn), 32'd1);
    check("t6_gnt_in_reset", 32'(wr_gnt), 32'd0);
    next_cycle();
    reset = 1'b0;
    drive(4'b1111, 1'b0, 32'h0);
    check("t6_fifo_wn", 32'(fifo_wn), 32'd0);
    check("t6_fifo_rn", 32'(fifo_rn), 32'd0);
    check("t6_rd_valid", 32'(rd_valid), 32'd0);
    check("t6_occupancy", 32'(occupancy), 32'd0);
    check("t6_wr_gnt_p0", 32'(wr_gnt), 32'b0001);
    next_cycle();

    // Randomized traffic, checked by the reference model every cycle.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) wr_req = 4'($urandom_range(0, 15));
      rd_req  = ($urandom_range(0, 2) != 0);
      wr_data = $urandom;
      reset   = ($urandom_range(0, 99) == 0);
      next_cycle();
    end
    reset  = 1'b0;
    wr_req = '0;
    rd_req = 1'b1;
    repeat (12) next_cycle();
    rd_req = 1'b0;
    repeat (3) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
